aer_event_readout: RTL and testbench
====================================

// Module: aer_event_readout
// PURPOSE
// Consumer end of the pixel-arbiter hierarchy: captures each granted pixel address (active_i, x/y) from the
// top-level arbiter, timestamps it with a free-running counter and buffers it in a FWFT FIFO. Drains over
// a valid/ready stream to the off-chip link. Raises stall_o so the arbiter holds grants when the buffer is
// nearly full. Inserts a marker word on every timestamp wrap so the host can rebuild absolute time.
// PARAMETERS
// X_W         4   row address width (x_add_i)
// Y_W         4   column address width (y_add_i)
// TS_W        16  timestamp / epoch counter width
// DEPTH       8   FIFO entries, power of two, >=4
// DROP_W      16  drop counter width
// PORTS
// clk_i          in   1                  clock
// reset_i        in   1                  synchronous, active-high reset
// active_i       in   1                  arbiter has a granted pixel this cycle
// x_add_i        in   X_W                granted pixel row address
// y_add_i        in   Y_W                granted pixel column address
// stall_o        out  1                  arbiter must hold grants (no new event accepted)
// evt_valid_o    out  1                  evt_data_o holds a word
// evt_ready_i    in   1                  downstream consumes word when valid&ready
// evt_data_o     out  1+TS_W+Y_W+X_W     {marker, ts/epoch, y, x}
// fill_o         out  $clog2(DEPTH)+1    FIFO occupancy
// drop_cnt_o     out  DROP_W             events lost, saturating
// BEHAVIOUR
// - Reset (synchronous): FIFO pointers/count 0, ts 0, epoch 0, marker_pend 0, drop_cnt 0. Outputs next
//   cycle: evt_valid_o=0, fill_o=0, drop_cnt_o=0, stall_o=0, evt_data_o=0. Reset mid-operation discards
//   all buffered words; no partial word is ever presented.
// - ts: increments every cycle, wraps all-ones -> 0. On wrap cycle epoch increments and marker_pend sets.
// - Event word: {1'b0, ts (value in the accept cycle, before increment), y_add_i, x_add_i}.
// - Marker word: {1'b1, epoch (post-increment), Y_W'0, X_W'0}.
// - One FIFO write per cycle, priority: marker_pend > event.
//   * marker_pend=1 and FIFO not full: write marker, clear marker_pend; active_i that cycle is dropped.
//   * marker_pend=0, active_i=1, FIFO not full: write event (1-cycle latency: evt_valid_o next cycle if empty).
//   * FIFO full: no write; active_i dropped; marker_pend stays set.
//   * Full means count==DEPTH; a same-cycle pop does NOT allow a write.
// - Event on the wrap cycle itself: event written with ts=all-ones; marker follows in a later cycle.
// - Each dropped active_i increments drop_cnt_o by 1, saturating at all-ones.
// - stall_o = (count >= DEPTH-1) | marker_pend, combinational from registers only (no input path).
// - Stream: FWFT; evt_valid_o = (count!=0); evt_data_o = mem[rd_ptr]; pop on valid&ready.
//   evt_data_o stable while valid & !ready. Simultaneous push and pop: count unchanged, order preserved.
// - Pointers wrap modulo DEPTH; fill_o = count, range 0..DEPTH.
// TESTING
// 1. Reset, ready=1, active_i=1 x=3 y=5 at ts=10 -> next cycle valid=1, data={0,16'd10,4'd5,4'd3}; fill returns 0.
// 2. ready=0, active_i held 10 cycles -> fill=8, stall_o=1 once fill>=7, drop_cnt_o=2, first 8 words in order.
// 3. active_i at ts=0xFFFF, ready=1 -> event {0,16'hFFFF,..} then marker {1,16'd1,0,0}; stall_o=1 while pend.
// 4. active_i high the cycle after wrap (marker_pend=1) -> marker written, event dropped, drop_cnt_o +1.
// 5. fill=4, push and pop same cycle -> fill stays 4, popped word is oldest; data stable while ready=0.
// 6. fill=3, reset_i pulse -> next cycle valid=0, fill=0, drop_cnt_o=0, ts restarts at 0.

Source files
------------

// File: rtl/aer_event_readout_if.sv
// Stream/handshake bundle between the pixel arbiter, the readout buffer and
// the off-chip link.
//   active_i, x_add_i, y_add_i : granted pixel from the top-level arbiter
//   stall_o                    : readout asks the arbiter to hold grants
//   evt_valid_o, evt_ready_i   : valid/ready stream towards the link
//   evt_data_o                 : {marker, ts/epoch, y, x}
// slave  = readout side, master = arbiter + link side.
interface aer_event_readout_if #(
    parameter int X_W  = 4,
    parameter int Y_W  = 4,
    parameter int TS_W = 16
);
    localparam int W = 1 + TS_W + Y_W + X_W;

    logic           active_i;
    logic [X_W-1:0] x_add_i;
    logic [Y_W-1:0] y_add_i;
    logic           stall_o;
    logic           evt_valid_o;
    logic           evt_ready_i;
    logic [W-1:0]   evt_data_o;

    modport slave (
        input  active_i, x_add_i, y_add_i, evt_ready_i,
        output stall_o, evt_valid_o, evt_data_o
    );

    modport master (
        output active_i, x_add_i, y_add_i, evt_ready_i,
        input  stall_o, evt_valid_o, evt_data_o
    );
endinterface

// File: rtl/aer_event_readout.sv
// Consumer end of the pixel-arbiter tree. Each granted address is stamped
// with a free-running counter and pushed into a first-word-fall-through
// FIFO that drains over a valid/ready stream. On every counter wrap a marker
// word carrying the new epoch is queued so the host can rebuild absolute time.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus            : arbiter inputs, stall, output stream (slave modport)
//   fill_o         : FIFO occupancy, 0..DEPTH
//   drop_cnt_o     : saturating count of grants that could not be stored
module aer_event_readout #(
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    aer_event_readout_if.slave       bus,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = 1 + TS_W + Y_W + X_W;

    logic [W-1:0]      mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [TS_W-1:0]   epoch_q, epoch_d;
    logic              marker_pend_q, marker_pend_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic          full, wrap, pop, push, push_marker, push_evt, drop;
    logic [W-1:0]  wr_data;

    always_comb begin
        // Full blocks a write even when the head is popped this cycle.
        full        = (count_q == CW'(DEPTH));
        wrap        = &ts_q;
        pop         = (count_q != '0) && bus.evt_ready_i;
        push_marker = marker_pend_q && !full;
        push_evt    = !marker_pend_q && bus.active_i && !full;
        push        = push_marker || push_evt;
        drop        = bus.active_i && !push_evt;

        // epoch_q already holds the post-wrap value by the time a marker goes out.
        wr_data = push_marker ? {1'b1, epoch_q, {(Y_W + X_W){1'b0}}}
                              : {1'b0, ts_q, bus.y_add_i, bus.x_add_i};

        ts_d          = ts_q + TS_W'(1);
        epoch_d       = wrap ? epoch_q + TS_W'(1) : epoch_q;
        marker_pend_d = (marker_pend_q && !push_marker) || wrap;
        drop_cnt_d    = (drop && !(&drop_cnt_q)) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ts_q          <= '0;
            epoch_q       <= '0;
            marker_pend_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ts_q          <= ts_d;
            epoch_q       <= epoch_d;
            marker_pend_q <= marker_pend_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage is not reset; the output mux below hides stale entries.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign bus.evt_valid_o = (count_q != '0);
    assign bus.evt_data_o  = bus.evt_valid_o ? mem_q[rd_ptr_q] : '0;
    assign bus.stall_o     = (count_q >= CW'(DEPTH - 1)) || marker_pend_q;
    assign fill_o          = count_q;
    assign drop_cnt_o      = drop_cnt_q;
endmodule

// File: tb/tb_aer_event_readout.sv
module tb_aer_event_readout;
    localparam int X_W = 4, Y_W = 4, TS_W = 16, DEPTH = 8, DROP_W = 16;
    localparam int W = 1 + TS_W + Y_W + X_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [CW-1:0]     fill;
    logic [DROP_W-1:0] drop;

    always #5 clk = ~clk;

    aer_event_readout_if #(.X_W(X_W), .Y_W(Y_W), .TS_W(TS_W)) bus ();

    aer_event_readout #(
        .X_W(X_W), .Y_W(Y_W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus), .fill_o(fill), .drop_cnt_o(drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of words plus counters.
    logic [W-1:0]      q[$];
    logic [TS_W-1:0]   m_ts;
    logic [TS_W-1:0]   m_epoch;
    logic              m_pend;
    logic [DROP_W-1:0] m_drop;

    // Drive one cycle of inputs and advance the model by the same cycle.
    // Returns at the following negedge, where outputs are checked.
    task automatic step(input logic rst, input logic act, input logic [X_W-1:0] x,
                        input logic [Y_W-1:0] y, input logic rdy);
        logic full;
        logic stored;
        reset = rst;
        bus.active_i = act;
        bus.x_add_i = x;
        bus.y_add_i = y;
        bus.evt_ready_i = rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ts = '0; m_epoch = '0; m_pend = 1'b0; m_drop = '0;
        end else begin
            full = (q.size() == DEPTH);
            stored = 1'b0;
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (m_pend && !full) begin
                q.push_back({1'b1, m_epoch, 8'h00});
                m_pend = 1'b0;
            end else if (!m_pend && act && !full) begin
                q.push_back({1'b0, m_ts, y, x});
                stored = 1'b1;
            end
            if (act && !stored && m_drop != '1) m_drop = m_drop + 1'b1;
            if (m_ts == '1) begin
                m_epoch = m_epoch + 1'b1;
                m_pend = 1'b1;
            end
            m_ts = m_ts + 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        n_checks++; if (bus.evt_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.evt_valid_o); end
        n_checks++; if (fill !== '0) begin n_errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        n_checks++; if (drop !== '0) begin n_errors++; $display("FAIL reset_drop: got %0d expected 0", drop); end
        n_checks++; if (bus.stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
        n_checks++; if (bus.evt_data_o !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", bus.evt_data_o); end
    endtask

    task automatic test_single_event();
        logic [W-1:0] exp;
        while (m_ts != 16'd10) step(0, 0, 0, 0, 1);
        step(0, 1, 4'd3, 4'd5, 1);
        exp = {1'b0, 16'd10, 4'd5, 4'd3};
        n_checks++; if (bus.evt_valid_o !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", bus.evt_valid_o); end
        n_checks++; if (bus.evt_data_o !== exp) begin n_errors++; $display("FAIL single_data: got %h expected %h", bus.evt_data_o, exp); end
        step(0, 0, 0, 0, 1);
        n_checks++; if (fill !== '0) begin n_errors++; $display("FAIL single_fill: got %0d expected 0", fill); end
    endtask

    task automatic test_fill_drop();
        logic [W-1:0] exp[10];
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        for (int i = 0; i < 10; i++) begin
            x = X_W'($urandom);
            y = Y_W'($urandom);
            exp[i] = {1'b0, m_ts, y, x};
            step(0, 1, x, y, 0);
            n_checks++;
            if (bus.stall_o !== (i + 1 >= DEPTH - 1)) begin
                n_errors++; $display("FAIL fill_stall[%0d]: got %b expected %b", i, bus.stall_o, (i + 1 >= DEPTH - 1));
            end
        end
        n_checks++; if (fill !== CW'(DEPTH)) begin n_errors++; $display("FAIL fill_full: got %0d expected %0d", fill, DEPTH); end
        n_checks++; if (drop !== 16'd2) begin n_errors++; $display("FAIL fill_drop: got %0d expected 2", drop); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (bus.evt_data_o !== exp[i]) begin n_errors++; $display("FAIL fill_order[%0d]: got %h expected %h", i, bus.evt_data_o, exp[i]); end
            step(0, 0, 0, 0, 1);
        end
        n_checks++; if (bus.evt_valid_o !== 1'b0) begin n_errors++; $display("FAIL fill_drained: got %b expected 0", bus.evt_valid_o); end
    endtask

    task automatic test_push_pop();
        logic [W-1:0] exp[5];
        for (int i = 0; i < 4; i++) begin
            exp[i] = {1'b0, m_ts, Y_W'(i), X_W'(i + 8)};
            step(0, 1, X_W'(i + 8), Y_W'(i), 0);
        end
        step(0, 0, 0, 0, 0);
        n_checks++; if (bus.evt_data_o !== exp[0]) begin n_errors++; $display("FAIL pp_stable: got %h expected %h", bus.evt_data_o, exp[0]); end
        exp[4] = {1'b0, m_ts, 4'hA, 4'h5};
        step(0, 1, 4'h5, 4'hA, 1);
        n_checks++; if (fill !== 4'd4) begin n_errors++; $display("FAIL pp_fill: got %0d expected 4", fill); end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (bus.evt_data_o !== exp[i]) begin n_errors++; $display("FAIL pp_order[%0d]: got %h expected %h", i, bus.evt_data_o, exp[i]); end
            step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
        for (int i = 0; i < 3; i++) step(0, 1, 4'h1, 4'h1, 0);
        n_checks++; if (fill !== 4'd3) begin n_errors++; $display("FAIL rm_fill_before: got %0d expected 3", fill); end
        step(1, 0, 0, 0, 0);
        n_checks++; if (bus.evt_valid_o !== 1'b0) begin n_errors++; $display("FAIL rm_valid: got %b expected 0", bus.evt_valid_o); end
        n_checks++; if (fill !== '0) begin n_errors++; $display("FAIL rm_fill: got %0d expected 0", fill); end
        n_checks++; if (drop !== '0) begin n_errors++; $display("FAIL rm_drop: got %0d expected 0", drop); end
        n_checks++; if (bus.evt_data_o !== '0) begin n_errors++; $display("FAIL rm_data: got %h expected 0", bus.evt_data_o); end
        step(0, 1, 4'h1, 4'h2, 0);
        exp = {1'b0, 16'd0, 4'h2, 4'h1};
        n_checks++; if (bus.evt_data_o !== exp) begin n_errors++; $display("FAIL rm_ts_restart: got %h expected %h", bus.evt_data_o, exp); end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [W-1:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            step(0, ($urandom_range(0, 99) < 55), X_W'($urandom), Y_W'($urandom),
                 ($urandom_range(0, 99) < 45));
            exp_data = (q.size() != 0) ? q[0] : '0;
            n_checks++; if (bus.evt_valid_o !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.evt_valid_o, (q.size() != 0)); end
            n_checks++; if (bus.evt_data_o !== exp_data) begin n_errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, bus.evt_data_o, exp_data); end
            n_checks++; if (fill !== CW'(q.size())) begin n_errors++; $display("FAIL rnd_fill[%0d]: got %0d expected %0d", i, fill, q.size()); end
            n_checks++; if (bus.stall_o !== ((q.size() >= DEPTH - 1) || m_pend)) begin n_errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, bus.stall_o, ((q.size() >= DEPTH - 1) || m_pend)); end
            n_checks++; if (drop !== m_drop) begin n_errors++; $display("FAIL rnd_drop[%0d]: got %0d expected %0d", i, drop, m_drop); end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp;
        logic [DROP_W-1:0] drop_before;
        while (m_ts != 16'hFFFF || q.size() != 0) step(0, 0, 0, 0, 1);
        drop_before = drop;
        step(0, 1, 4'h7, 4'h9, 0);
        exp = {1'b0, 16'hFFFF, 4'h9, 4'h7};
        n_checks++; if (bus.evt_data_o !== exp) begin n_errors++; $display("FAIL wrap_event: got %h expected %h", bus.evt_data_o, exp); end
        n_checks++; if (bus.stall_o !== 1'b1) begin n_errors++; $display("FAIL wrap_stall_pend: got %b expected 1", bus.stall_o); end
        step(0, 1, 4'h3, 4'h3, 0);
        n_checks++; if (fill !== 4'd2) begin n_errors++; $display("FAIL wrap_fill: got %0d expected 2", fill); end
        n_checks++; if (drop !== drop_before + 1'b1) begin n_errors++; $display("FAIL wrap_drop: got %0d expected %0d", drop, drop_before + 1'b1); end
        n_checks++; if (bus.stall_o !== 1'b0) begin n_errors++; $display("FAIL wrap_stall_clear: got %b expected 0", bus.stall_o); end
        step(0, 0, 0, 0, 1);
        exp = {1'b1, 16'd1, 8'h00};
        n_checks++; if (bus.evt_data_o !== exp) begin n_errors++; $display("FAIL wrap_marker: got %h expected %h", bus.evt_data_o, exp); end
        step(0, 0, 0, 0, 1);
        n_checks++; if (bus.evt_valid_o !== 1'b0) begin n_errors++; $display("FAIL wrap_drained: got %b expected 0", bus.evt_valid_o); end
    endtask

    initial begin
        bus.active_i = 1'b0;
        bus.x_add_i = '0;
        bus.y_add_i = '0;
        bus.evt_ready_i = 1'b1;
        m_ts = '0; m_epoch = '0; m_pend = 1'b0; m_drop = '0;
        @(negedge clk);
        test_reset();
        test_single_event();
        test_fill_drop();
        test_push_pop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
